// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/divider/exception requests in,
// stall/flush/redirect and divider handshake out.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_id;
  logic             ex_div_req;
  logic             div_ready;
  logic             excp_valid;
  logic             excp_is_eret;
  logic [31:0]      cp0_epc;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             div_start;
  logic             div_cancel;
  logic             div_busy;
  logic             div_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output stallreq_id, ex_div_req, div_ready,
    output excp_valid, excp_is_eret, cp0_epc,
    input  stall, flush, new_pc,
    input  div_start, div_cancel, div_busy,
    input  div_timeout, stall_cnt
  );

  modport slave (
    input  stallreq_id, ex_div_req, div_ready,
    input  excp_valid, excp_is_eret, cp0_epc,
    output stall, flush, new_pc,
    output div_start, div_cancel, div_busy,
    output div_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall vector, exception/ERET flush
// and redirect, and the multi-cycle divider start/wait/cancel handshake.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int          DIV_TIMEOUT = 40,
  parameter int          CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);
  localparam int WCW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(DIV_TIMEOUT);
  localparam logic [5:0] ST_EX = 6'b001111;
  localparam logic [5:0] ST_ID = 6'b000111;

  typedef enum logic {
    RUN,
    DIV_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             tmo_q;
  logic [CNT_W-1:0] scnt_q;

  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic        start_c;
  logic        cancel_c;

  always_comb begin
    stall_c  = '0;
    flush_c  = 1'b0;
    new_pc_c = '0;
    start_c  = 1'b0;
    cancel_c = 1'b0;
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    if (rst) begin
      state_d = RUN;
      wcnt_d  = '0;
    end else if (bus.excp_valid) begin
      flush_c  = 1'b1;
      new_pc_c = bus.excp_is_eret ? bus.cp0_epc
                                  : EXC_VECTOR;
      cancel_c = (state_q == DIV_WAIT);
      state_d  = RUN;
      wcnt_d   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.ex_div_req) begin
            start_c = 1'b1;
            stall_c = ST_EX;
            state_d = DIV_WAIT;
            wcnt_d  = '0;
          end else if (bus.stallreq_id) begin
            stall_c = ST_ID;
          end
        end
        DIV_WAIT: begin
          if (bus.div_ready) begin
            // EX retires the quotient at this edge
            stall_c = bus.stallreq_id ? ST_ID : '0;
            state_d = RUN;
          end else begin
            stall_c = ST_EX;
            if (wcnt_q != WMAX)
              wcnt_d = wcnt_q + WCW'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_q == DIV_WAIT && wcnt_d == WMAX)
        tmo_q <= 1'b1;
      if (stall_c[0])
        scnt_q <= scnt_q + CNT_W'(1);
    end
  end

  assign bus.stall       = stall_c;
  assign bus.flush       = flush_c;
  assign bus.new_pc      = new_pc_c;
  assign bus.div_start   = start_c;
  assign bus.div_cancel  = cancel_c;
  assign bus.div_busy    = (state_q == DIV_WAIT);
  assign bus.div_timeout = tmo_q;
  assign bus.stall_cnt   = scnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, ID hazard, divide sequencing,
// exceptions, ERET, timeout and reset during a divide.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) bus ();

  pipe_ctrl #(
    .EXC_VECTOR (32'hBFC00380),
    .DIV_TIMEOUT(40),
    .CNT_W      (32)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic idle();
    bus.stallreq_id  = 1'b0;
    bus.ex_div_req   = 1'b0;
    bus.div_ready    = 1'b0;
    bus.excp_valid   = 1'b0;
    bus.excp_is_eret = 1'b0;
    bus.cp0_epc      = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.excp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.flush !== 1'b0 || bus.stall !== 6'd0) begin
      errors++;
      $display("FAIL rst_comb: flush=%b stall=%b req 0/0",
               bus.flush, bus.stall);
    end
    checks++;
    if (bus.new_pc !== 32'd0 || bus.div_start !== 1'b0
        || bus.div_cancel !== 1'b0) begin
      errors++;
      $display("FAIL rst_pc: new_pc=%h start=%b cancel=%b req 0",
               bus.new_pc, bus.div_start, bus.div_cancel);
    end
    cyc();
    cyc();
    checks++;
    if (bus.div_busy !== 1'b0 || bus.div_timeout !== 1'b0
        || bus.stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_regs: busy=%b tmo=%b cnt=%0d req 0",
               bus.div_busy, bus.div_timeout, bus.stall_cnt);
    end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_id_stall();
    bus.stallreq_id = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall !== 6'b000111) begin
      errors++;
      $display("FAIL id_stall: got %b req 000111", bus.stall);
    end
    cyc();
    bus.stallreq_id = 1'b0;
    checks++;
    if (bus.stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL id_cnt: got %0d req 1", bus.stall_cnt);
    end
    @(negedge clk);
    checks++;
    if (bus.stall !== 6'd0) begin
      errors++;
      $display("FAIL id_release: got %b req 0", bus.stall);
    end
    cyc();
  endtask

  task automatic test_div();
    bus.ex_div_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.div_start !== 1'b1 || bus.stall !== 6'b001111
        || bus.div_busy !== 1'b0) begin
      errors++;
      $display("FAIL div_start: start=%b stall=%b busy=%b req 1/001111/0",
               bus.div_start, bus.stall, bus.div_busy);
    end
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.div_start !== 1'b0 || bus.stall !== 6'b001111
          || bus.div_busy !== 1'b1) begin
        errors++;
        $display("FAIL div_wait%0d: start=%b stall=%b busy=%b req 0/001111/1",
                 i, bus.div_start, bus.stall, bus.div_busy);
      end
      cyc();
    end
    bus.div_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall !== 6'd0 || bus.div_cancel !== 1'b0
        || bus.div_start !== 1'b0) begin
      errors++;
      $display("FAIL div_ready: stall=%b cancel=%b start=%b req 0",
               bus.stall, bus.div_cancel, bus.div_start);
    end
    cyc();
    idle();
    checks++;
    if (bus.div_busy !== 1'b0 || bus.stall_cnt !== 32'd7) begin
      errors++;
      $display("FAIL div_done: busy=%b cnt=%0d req 0/7",
               bus.div_busy, bus.stall_cnt);
    end
  endtask

  task automatic test_ready_in_run();
    bus.div_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall !== 6'd0 || bus.div_start !== 1'b0) begin
      errors++;
      $display("FAIL run_ready: stall=%b start=%b req 0",
               bus.stall, bus.div_start);
    end
    cyc();
    idle();
    checks++;
    if (bus.div_busy !== 1'b0) begin
      errors++;
      $display("FAIL run_ready_busy: got %b req 0", bus.div_busy);
    end
  endtask

  task automatic test_back_to_back();
    bus.ex_div_req = 1'b1;
    cyc();
    bus.div_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall !== 6'd0 || bus.div_busy !== 1'b1) begin
      errors++;
      $display("FAIL min_div: stall=%b busy=%b req 0/1",
               bus.stall, bus.div_busy);
    end
    cyc();
    bus.div_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_start !== 1'b1 || bus.div_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start: start=%b busy=%b req 1/0",
               bus.div_start, bus.div_busy);
    end
    cyc();
    bus.div_ready = 1'b1;
    bus.stallreq_id = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall !== 6'b000111) begin
      errors++;
      $display("FAIL ready_id: got %b req 000111", bus.stall);
    end
    cyc();
    idle();
    checks++;
    if (bus.div_busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_id_run: busy=%b req 0", bus.div_busy);
    end
  endtask

  task automatic test_div_excp();
    bus.ex_div_req = 1'b1;
    cyc();
    cyc();
    bus.excp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.flush !== 1'b1 || bus.div_cancel !== 1'b1
        || bus.new_pc !== 32'hBFC00380) begin
      errors++;
      $display("FAIL excp_flush: flush=%b cancel=%b pc=%h req 1/1/bfc00380",
               bus.flush, bus.div_cancel, bus.new_pc);
    end
    checks++;
    if (bus.stall !== 6'd0 || bus.div_start !== 1'b0) begin
      errors++;
      $display("FAIL excp_stall: stall=%b start=%b req 0",
               bus.stall, bus.div_start);
    end
    cyc();
    idle();
    checks++;
    if (bus.div_busy !== 1'b0) begin
      errors++;
      $display("FAIL excp_state: busy=%b req 0", bus.div_busy);
    end
    @(negedge clk);
    checks++;
    if (bus.flush !== 1'b0 || bus.new_pc !== 32'd0) begin
      errors++;
      $display("FAIL excp_end: flush=%b pc=%h req 0",
               bus.flush, bus.new_pc);
    end
    cyc();
  endtask

  task automatic test_excp_ready();
    bus.ex_div_req = 1'b1;
    cyc();
    bus.div_ready  = 1'b1;
    bus.excp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.div_cancel !== 1'b1 || bus.flush !== 1'b1
        || bus.stall !== 6'd0) begin
      errors++;
      $display("FAIL excp_ready: cancel=%b flush=%b stall=%b req 1/1/0",
               bus.div_cancel, bus.flush, bus.stall);
    end
    cyc();
    idle();
  endtask

  task automatic test_eret();
    bus.excp_valid   = 1'b1;
    bus.excp_is_eret = 1'b1;
    bus.cp0_epc      = 32'h8000_0100;
    bus.ex_div_req   = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.new_pc !== 32'h8000_0100 || bus.flush !== 1'b1) begin
      errors++;
      $display("FAIL eret_pc: pc=%h flush=%b req 80000100/1",
               bus.new_pc, bus.flush);
    end
    checks++;
    if (bus.div_start !== 1'b0 || bus.div_cancel !== 1'b0) begin
      errors++;
      $display("FAIL eret_div: start=%b cancel=%b req 0/0",
               bus.div_start, bus.div_cancel);
    end
    cyc();
    idle();
    @(negedge clk);
    checks++;
    if (bus.flush !== 1'b0 || bus.div_busy !== 1'b0) begin
      errors++;
      $display("FAIL eret_once: flush=%b busy=%b req 0/0",
               bus.flush, bus.div_busy);
    end
    cyc();
  endtask

  task automatic test_timeout();
    bus.ex_div_req = 1'b1;
    cyc();
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++;
      if (bus.div_timeout !== 1'b0 || bus.stall !== 6'b001111) begin
        errors++;
        $display("FAIL tmo_wait%0d: tmo=%b stall=%b req 0/001111",
                 i, bus.div_timeout, bus.stall);
      end
      cyc();
    end
    checks++;
    if (bus.div_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_rise: got %b req 1", bus.div_timeout);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.div_timeout !== 1'b1 || bus.stall !== 6'b001111
          || bus.div_busy !== 1'b1) begin
        errors++;
        $display("FAIL tmo_hold%0d: tmo=%b stall=%b busy=%b req 1/001111/1",
                 i, bus.div_timeout, bus.stall, bus.div_busy);
      end
      cyc();
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.div_cancel !== 1'b0 || bus.stall !== 6'd0
        || bus.div_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_div: cancel=%b stall=%b start=%b req 0",
               bus.div_cancel, bus.stall, bus.div_start);
    end
    cyc();
    checks++;
    if (bus.div_busy !== 1'b0 || bus.div_timeout !== 1'b0
        || bus.stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_clear: busy=%b tmo=%b cnt=%0d req 0",
               bus.div_busy, bus.div_timeout, bus.stall_cnt);
    end
    rst = 1'b0;
    idle();
    cyc();
  endtask

  initial begin
    idle();
    test_reset();
    test_id_stall();
    test_div();
    test_ready_in_run();
    test_back_to_back();
    test_div_excp();
    test_excp_ready();
    test_eret();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
